// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter:
// FSM state encoding and the default frame width.
package piso_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx.
// The master side supplies words; the slave side (the transmitter) serializes them.
interface piso_tx_if
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             msb_first;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output din, load_valid, msb_first,
    input  load_ready, sout, sout_valid, done
  );

  modport slave (
    input  din, load_valid, msb_first,
    output load_ready, sout, sout_valid, done
  );

endinterface

// File: rtl/piso_tx_shift_reg_core.sv
// Parallel-load, bidirectional, zero-fill shift register.
// sbit is the bit that leaves the register on the next shift in direction dir.
module shift_reg_core
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic             sbit
);

  logic [WIDTH-1:0] shreg;

  // Load has priority over shift; dir = 1 moves bits toward the MSB end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= dir ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign sbit = dir ? shreg[WIDTH-1] : shreg[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter. A word accepted on the load
// handshake is emitted one bit per clock, starting the cycle after
// acceptance. A new word can be accepted during the last bit of the
// current frame so frames run back to back without a gap.
// All outputs decode registered state only, so reset clears them at once.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  piso_tx_if.slave   bus
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             dir_q;
  logic             last;
  logic             accept;
  logic             load_en;
  logic             shift_en;
  logic             sbit;

  assign last           = (state == SHIFT) && (cnt == LAST_CNT);
  assign bus.load_ready = !rst && ((state == IDLE) || last);
  assign accept         = bus.load_valid && bus.load_ready;

  shift_reg_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load_en),
    .shift (shift_en),
    .dir   (dir_q),
    .din   (bus.din),
    .sbit  (sbit)
  );

  // State, bit counter and per-frame direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load_en) begin
        dir_q <= bus.msb_first;
      end
    end
  end

  // Next state: accept in IDLE or on the last bit, otherwise advance one bit.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          load_en = 1'b1;
        end
      end
      SHIFT: begin
        if (accept) begin
          cnt_d   = '0;
          load_en = 1'b1;
        end else if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout       = (state == SHIFT) && sbit;
  assign bus.done       = last;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, frame length in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: din  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port: load_valid  input  1  din valid, request to start a frame.
REQ-006 SHALL have port: load_ready  output  1  block can accept din this cycle.
REQ-007 SHALL have port: msb_first  input  1  1 = shift left (MSB out first); 0 = shift right (LSB out first); sampled at acceptance only.
REQ-008 SHALL have port: sout  output  1  serial data out, registered.
REQ-009 SHALL have port: sout_valid  output  1  sout carries a frame bit, registered.
REQ-010 SHALL have port: done  output  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-011 SHALL implement two states: IDLE and SHIFT.
REQ-012 SHALL accept a word on a rising edge where load_valid && load_ready, capturing din into the shift register, latching msb_first into dir_q, clearing bit counter cnt, and entering SHIFT.
REQ-013 SHALL drive load_ready = 1 in IDLE, and in SHIFT only while cnt == WIDTH-1 (last bit), allowing back-to-back frames with no gap.
REQ-014 SHALL present the first bit on sout (with sout_valid = 1) in the cycle immediately after the acceptance edge (latency 1).
REQ-015 SHALL output shreg[WIDTH-1] when dir_q = 1 and shreg[0] when dir_q = 0, advancing one bit per clock and filling vacated positions with 0.
REQ-016 SHALL increment cnt (width clog2(WIDTH)) once per SHIFT cycle; cnt SHALL never wrap within a frame.
REQ-017 SHALL assert done for exactly the cycle in which cnt == WIDTH-1 with sout_valid = 1.
REQ-018 SHALL, at the end of the last-bit cycle, return to IDLE if no acceptance occurs, or remain in SHIFT with the new word, cnt = 0, and the new dir_q if an acceptance occurs.
REQ-019 SHALL ignore load_valid, din and msb_first while in SHIFT with cnt < WIDTH-1, without sampling them or disturbing the frame.
REQ-020 SHALL ignore changes on msb_first mid-frame; direction is fixed per frame by dir_q.
REQ-021 SHALL drive sout = 0, sout_valid = 0 and done = 0 in IDLE.

Reset
REQ-022 SHALL, on rst = 1 (asynchronous, including mid-frame), force state IDLE, shreg = 0, cnt = 0, dir_q = 0, sout = 0, sout_valid = 0 and done = 0, abandoning any partial frame.
REQ-023 SHALL drive load_ready = 0 while rst is asserted and load_ready = 1 on the first clock after rst deasserts.
REQ-024 SHALL not accept a word on any edge where rst is asserted.

Structure
REQ-025 SHALL place the state encoding (IDLE, SHIFT) and the default WIDTH constant in a shared shift-register package.
REQ-026 SHALL use one sub-module, shift_reg_core (parallel-load, bidirectional, zero-fill register with load/shift enables); the FSM, counter and handshake logic SHALL live in piso_tx.

Verification (WIDTH = 8)
REQ-027 SHALL cover: load 8'h1E, msb_first = 1 -> sout 0,0,0,1,1,1,1,0 on cycles 1-8 after acceptance, done on cycle 8, then IDLE.
REQ-028 SHALL cover: load 8'h1E, msb_first = 0 -> sout 0,1,1,1,1,0,0,0, done on cycle 8.
REQ-029 SHALL cover: back-to-back, 8'hFF (MSB first) then 8'h01 (LSB first) with load_valid held -> 16 contiguous valid bits 1×8 then 1,0,0,0,0,0,0,0, two done pulses, no gap.
REQ-030 SHALL cover: load_valid = 1 with din = 8'h00 pulsed at cycle 3 of an 8'hAA frame -> ignored, frame completes as 1,0,1,0,1,0,1,0.
REQ-031 SHALL cover: toggling msb_first mid-frame of 8'hF0 (MSB first) -> output unchanged, 1,1,1,1,0,0,0,0.
REQ-032 SHALL cover: rst asserted between clock edges at cycle 4 of a frame -> sout, sout_valid and done go 0 immediately; load_ready = 1 on the first clock after release; the next frame starts cleanly.
